// File: rtl/blink_scorer_if.sv
// rtl/blink_scorer_if.sv - button/LED inputs and score/judgement outputs of blink_scorer
interface blink_scorer_if;
    logic       btn;
    logic       sclk;
    logic [3:0] score;
    logic       hit;
    logic       miss;
    logic       win;

    modport master (output btn, output sclk, input score, input hit, input miss, input win);
    modport slave  (input btn, input sclk, output score, output hit, output miss, output win);
endinterface

// File: rtl/blink_scorer.sv
// rtl/blink_scorer.sv - debounces the button, judges presses against the LED and keeps the score
module blink_scorer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_SCORE       = 10
) (
    input  logic           clk,
    input  logic           reset,
    blink_scorer_if.slave  bus
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]     MAX_SC   = 4'(MAX_SCORE);

    typedef enum logic [1:0] {ARMED, LOCKED, WIN} state_t;

    logic          btn_m, btn_s, led_m, led_s, led_q;
    logic          btn_db, btn_db_q;
    logic [CW-1:0] cnt;
    logic          press, led_fall;

    state_t        state_q, state_d;
    logic [3:0]    score_q, score_d;
    logic          hit_q, hit_d, miss_q, miss_d;

    // Both inputs are asynchronous to clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            led_m <= 1'b0;
            led_s <= 1'b0;
            led_q <= 1'b0;
        end else begin
            btn_m <= bus.btn;
            btn_s <= btn_m;
            led_m <= bus.sclk;
            led_s <= led_m;
            led_q <= led_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_db <= 1'b0;
            cnt    <= '0;
        end else if (btn_s == btn_db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            btn_db <= btn_s;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) btn_db_q <= 1'b0;
        else       btn_db_q <= btn_db;
    end

    assign press    = btn_db & ~btn_db_q;
    assign led_fall = led_q & ~led_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARMED;
            score_q <= 4'd0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    // One judged attempt per blink period: any judgement locks until the next LED fall.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        case (state_q)
            ARMED: begin
                if (press) begin
                    if (led_s) begin
                        hit_d   = 1'b1;
                        score_d = score_q + 4'd1;
                        state_d = ((score_q + 4'd1) == MAX_SC) ? WIN : LOCKED;
                    end else begin
                        miss_d  = 1'b1;
                        score_d = (score_q == 4'd0) ? 4'd0 : score_q - 4'd1;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (led_fall) state_d = ARMED;
            end
            WIN: begin
                score_d = MAX_SC;
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    assign bus.score = score_q;
    assign bus.hit   = hit_q;
    assign bus.miss  = miss_q;
    assign bus.win   = (state_q == WIN);
endmodule

// File: tb/tb_blink_scorer.sv
// tb/tb_blink_scorer.sv - self-checking bench for blink_scorer
module tb_blink_scorer;
    localparam int D    = 4;
    localparam int MAXS = 3;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    blink_scorer_if bus();
    blink_scorer #(.DEBOUNCE_CYCLES(D), .MAX_SCORE(MAXS)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int   tests = 0;
    int   fails = 0;
    int   pos = 0;
    logic led_on = 1'b0;
    int   edge_n = 0;
    int   nhit, nmiss;

    logic bh [0:7];
    logic sh [0:7];
    logic m_db, m_db_prev, m_locked, m_won, m_hit, m_miss;
    int   m_score;

    typedef struct {
        logic want;
        int   len;
        int   exp_hit;
        int   exp_miss;
        int   exp_score;
        int   exp_win;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference: bh/sh hold the btn/sclk values sampled at previous edges (index 0 = latest).
    task automatic model_edge(input logic b, input logic s, input logic r);
        logic press, fall, led, flip;
        if (r) begin
            for (int j = 0; j < 8; j++) begin
                bh[j] = 1'b0;
                sh[j] = 1'b0;
            end
            m_db = 0; m_db_prev = 0; m_locked = 0; m_won = 0;
            m_hit = 0; m_miss = 0; m_score = 0;
        end else begin
            press = m_db && !m_db_prev;
            fall  = sh[2] && !sh[1];
            led   = sh[1];
            m_hit = 0;
            m_miss = 0;
            if (m_won) begin
            end else if (m_locked) begin
                if (fall) m_locked = 0;
            end else if (press) begin
                if (led) begin
                    m_hit = 1;
                    m_score++;
                    if (m_score == MAXS) m_won = 1;
                    else m_locked = 1;
                end else begin
                    m_miss = 1;
                    if (m_score > 0) m_score--;
                    m_locked = 1;
                end
            end
            flip = 1;
            for (int j = 1; j <= D; j++) if (bh[j] == m_db) flip = 0;
            m_db_prev = m_db;
            if (flip) m_db = !m_db;
            for (int j = 7; j > 0; j--) begin
                bh[j] = bh[j-1];
                sh[j] = sh[j-1];
            end
            bh[0] = b;
            sh[0] = s;
        end
    endtask

    task automatic tick(input logic b, input logic r);
        bus.btn  = b;
        bus.sclk = led_on;
        rst      = r;
        @(posedge clk);
        model_edge(b, led_on, r);
        edge_n++;
        pos++;
        if (pos == HALF) begin
            pos = 0;
            led_on = !led_on;
        end
        #1;
        check("model_score", int'(bus.score), m_score);
        check("model_hit", int'(bus.hit), int'(m_hit));
        check("model_miss", int'(bus.miss), int'(m_miss));
        check("model_win", int'(bus.win), int'(m_won));
        if (bus.hit) nhit++;
        if (bus.miss) nmiss++;
    endtask

    task automatic wait_phase(input logic want, input int off);
        int guard = 0;
        while (!(led_on == want && pos == off) && guard < 4 * HALF) begin
            tick(1'b0, 1'b0);
            guard++;
        end
        check("wait_phase_timeout", guard < 4 * HALF ? 1 : 0, 1);
    endtask

    initial begin
        int hit_edge;
        int seg_end;
        logic lvl;

        tbl[0] = '{1'b1, 10, 1, 0, 2, 0};
        tbl[1] = '{1'b0, 10, 0, 1, 1, 0};
        tbl[2] = '{1'b0, 10, 0, 1, 0, 0};
        tbl[3] = '{1'b0, 10, 0, 1, 0, 0};
        tbl[4] = '{1'b1, 10, 0, 0, 0, 0};
        tbl[5] = '{1'b1, 10, 1, 0, 1, 0};
        tbl[6] = '{1'b1, 10, 1, 0, 2, 0};
        tbl[7] = '{1'b1, 10, 1, 0, 3, 1};
        tbl[8] = '{1'b1, 10, 0, 0, 3, 1};
        tbl[9] = '{1'b0, 10, 0, 0, 3, 1};

        repeat (3) tick(1'b0, 1'b1);
        check("reset_score", int'(bus.score), 0);
        check("reset_hit", int'(bus.hit), 0);
        check("reset_miss", int'(bus.miss), 0);
        check("reset_win", int'(bus.win), 0);
        nhit = 0; nmiss = 0;
        repeat (200) tick(1'b0, 1'b0);
        check("idle_hits", nhit, 0);
        check("idle_misses", nmiss, 0);

        wait_phase(1'b1, 1);
        nhit = 0;
        repeat (3) tick(1'b1, 1'b0);
        repeat (6) tick(1'b0, 1'b0);
        check("glitch_hits", nhit, 0);
        check("glitch_score", int'(bus.score), 0);

        wait_phase(1'b1, 12);
        hit_edge = -1;
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0);
            if (bus.hit && hit_edge < 0) hit_edge = k;
        end
        check("press_latency", hit_edge, D + 2);
        check("press_score", int'(bus.score), 1);
        repeat (6) tick(1'b0, 1'b0);

        wait_phase(1'b1, 29);
        nhit = 0; nmiss = 0;
        repeat (8) tick(1'b1, 1'b0);
        repeat (8) tick(1'b0, 1'b0);
        check("same_phase_hits", nhit, 0);
        check("same_phase_score", int'(bus.score), 1);

        for (int i = 0; i < 10; i++) begin
            wait_phase(tbl[i].want, 5);
            nhit = 0; nmiss = 0;
            repeat (tbl[i].len) tick(1'b1, 1'b0);
            repeat (10) tick(1'b0, 1'b0);
            check($sformatf("vec%0d_hits", i), nhit, tbl[i].exp_hit);
            check($sformatf("vec%0d_misses", i), nmiss, tbl[i].exp_miss);
            check($sformatf("vec%0d_score", i), int'(bus.score), tbl[i].exp_score);
            check($sformatf("vec%0d_win", i), int'(bus.win), tbl[i].exp_win);
        end

        tick(1'b0, 1'b1);
        check("win_reset_score", int'(bus.score), 0);
        check("win_reset_win", int'(bus.win), 0);

        wait_phase(1'b1, 5);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        hit_edge = -1;
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 1'b0);
            if (bus.hit && hit_edge < 0) hit_edge = k;
        end
        check("held_reset_latency", hit_edge, D + 2);
        check("held_reset_score", int'(bus.score), 1);
        repeat (10) tick(1'b0, 1'b0);

        seg_end = edge_n + 3000;
        while (edge_n < seg_end) begin
            if ($urandom_range(0, 39) == 0) begin
                tick(1'b0, 1'b1);
            end else begin
                lvl = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 12)) tick(lvl, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/blink_scorer.md
# blink_scorer

Judges player button presses against the blinking LED and maintains the 4-bit game score. It consumes the LED blink signal `sclk` produced by `clk_div` and returns the `score` that `clk_div` uses to set its blink rate, closing the game loop. The block synchronizes and debounces the raw button, allows one judged attempt per blink period, and latches a win condition.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); must be ≥ 2.
- MAX_SCORE, 10: score at which the game is won; must be in 1..15.

Ports:
- clk, input, 1: system clock. This is the only clock.
- reset, input, 1: synchronous, active-high reset.
- btn, input, 1: raw asynchronous push button, active-high.
- sclk, input, 1: LED blink level from `clk_div`. 1 means the LED is on. It is treated as asynchronous.
- score, output, 4: current score, which feeds `clk_div.score`.
- hit, output, 1: one-cycle pulse when a press is judged during LED on.
- miss, output, 1: one-cycle pulse when a press is judged during LED off.
- win, output, 1: level, high once score reaches MAX_SCORE.

## Operation
- Synchronizers
  - `btn` → 2-FF chain → `btn_s`.
  - `sclk` → 2-FF chain → `led_s`.
  - `led_q` is `led_s` delayed one cycle.
  - `led_fall` = `led_q & ~led_s`.
- Debouncer
  - Holds `btn_db` (reset 0) and counter `cnt` of width $clog2(DEBOUNCE_CYCLES).
  - If `btn_s == btn_db`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `btn_db <= btn_s` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - A glitch shorter than DEBOUNCE_CYCLES never changes `btn_db`.
- Press detect: `press` = `btn_db & ~btn_db_q`, where `btn_db_q` is `btn_db` registered. Releases are never judged.
- FSM states: ARMED, LOCKED, WIN.
  - ARMED, `press` and `led_s`=1:
    - Assert `hit`; `score <= score+1`.
    - Go to WIN if `score+1 == MAX_SCORE`, else go to LOCKED.
  - ARMED, `press` and `led_s`=0:
    - Assert `miss`; `score <= score-1`, saturating at 0.
    - Go to LOCKED.
  - LOCKED:
    - Presses are ignored.
    - On `led_fall`, go to ARMED.
    - A press in the same cycle as `led_fall` is ignored.
  - WIN:
    - `win`=1; `score` is held at MAX_SCORE.
    - All presses are ignored. Only `reset` exits this state.
- Arithmetic: 4-bit unsigned. Score never exceeds MAX_SCORE and never wraps below 0.
- Reset values
  - Outputs: `score`=0, `hit`=0, `miss`=0, `win`=0.
  - Internal: state ARMED; `btn_db`, `btn_db_q`, `cnt`, both sync chains, and `led_q` are all 0.
- Reset mid-operation: everything is cleared on the reset edge. If the button is held through reset, it is re-debounced from `btn_db`=0 and counts as a fresh press.

## Timing
- Edge 0 is the first clk edge that samples `btn`=1, with `btn` held stable afterwards.
  - `btn_s`=1 after edge 1.
  - `btn_db`=1 after edge DEBOUNCE_CYCLES+1.
  - `hit`/`miss` are high and `score` is updated after edge DEBOUNCE_CYCLES+2.
- The LED level judged is `led_s` at that edge, i.e. `sclk` as it was 2 edges earlier.
- `hit` and `miss` are each exactly 1 cycle wide and are never high together.
- `win` rises on the same edge as the final `hit` and the `score`=MAX_SCORE update.
- Attempt rate: at most one judged press between successive `led_fall` events.
  - Consequence: a miss during LED off locks out the entire following on-phase.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, MAX_SCORE=3, `sclk` toggling every 40 cycles.

1. Reset, then hold `btn`=0 → `score`=0, `hit`=`miss`=`win`=0, and no pulses for 200 cycles.
2. Glitch: `btn` high for 3 cycles during LED on → no `hit` and `score` stays 0. Then `btn` high for 10 cycles while LED is on → `hit` pulse exactly 6 edges after first sample and `score`=1.
3. Second press in the same on-phase → ignored, `score` stays 1. After `led_fall`, a press in the next on-phase → `hit`, `score`=2.
4. Press during LED off with `score`=2 → `miss`, `score`=1. Press during LED off with `score`=0 → `miss`, `score` stays 0 (saturation).
5. Three hits in three on-phases → `score`=3 and `win`=1 on the third hit edge. Further on-phase presses → no `hit`, `score` stays 3. Assert `reset` for 1 cycle → `score`=0, `win`=0.
6. Hold `btn`=1 across a reset pulse with LED on → after reset, `hit` asserts 6 edges after the first post-reset sample and `score`=1.
